mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one fixed-latency, single-ported memory between the instruction-fetch stage (PC/IF_ID side) and the data-access stage (ALU_MEM/MEM_WB side) of the 5-stage core. It accepts at most one transaction at a time and gives data-stage requests priority. It drives the shared port, returns read data to each requester with a one-cycle valid pulse, and produces stall levels for the existing locker logic. A branch flush cancels an outstanding fetch, and the fetch result is discarded.

## Interface
- LATENCY, 2: cycles from the port request cycle to the cycle in which `portRData` is valid; legal range 1..7.
- DATA_W, 32: data and address width (matches `DataSize`).
- clk  in  1  system clock, rising edge.
- resetIn  in  1  asynchronous, active-low reset.
- ifReq  in  1  fetch request; held stable with `ifAddr` until `ifValid` or `ifFlush`.
- ifAddr  in  DATA_W  fetch address.
- ifFlush  in  1  branch flush (`branchFlag`).
- ifValid  out  1  one-cycle pulse; `ifData` is valid.
- ifData  out  DATA_W  fetched instruction (registered).
- ifStall  out  1  `ifReq & ~ifValid`; feeds the PC and IF_ID lockers.
- memReq  in  1  data request; held stable with its qualifiers until `memValid`.
- memWrite  in  1  1 = store, 0 = load.
- memAddr  in  DATA_W  data address.
- memWData  in  DATA_W  store data.
- memByteEn  in  4  store byte enables.
- memValid  out  1  one-cycle pulse; load data valid or store done.
- memRData  out  DATA_W  load data (registered); 0 after a store.
- memStall  out  1  `memReq & ~memValid`.
- portReq  out  1  one-cycle request strobe to memory.
- portWrite  out  1  write qualifier.
- portAddr  out  DATA_W  port address.
- portWData  out  DATA_W  port write data.
- portByteEn  out  4  port byte enables; 4'b1111 for fetch and loads.
- portRData  in  DATA_W  read data, valid LATENCY cycles after the `portReq` cycle.

## Operation
- State register values: IDLE, BUSY_IF, BUSY_MEM. There is also a 3-bit down-counter `cnt` and a 1-bit `drop` flag.
- Accepting a request (IDLE only): at a rising edge, if `memReq` is high, the arbiter latches the data request and moves to BUSY_MEM. Otherwise, if `ifReq & ~ifFlush`, it latches the fetch and moves to BUSY_IF. Otherwise it stays in IDLE.
- Priority: data over fetch when both requests are present. A fetch that loses arbitration is retried in the next IDLE cycle.
- `port*` outputs are registered. `portReq` is high only in the first busy cycle. `portAddr`, `portWrite`, `portWData` and `portByteEn` hold their values for the whole busy period.
- On entering a busy state, `cnt` loads LATENCY. It decrements every cycle while busy.
- Completion: in the busy cycle with `cnt==0`, the arbiter registers `portRData` into `ifData`/`memRData`. At the same edge it returns to IDLE and asserts the matching valid for the next cycle.
- Flush: `ifFlush` high in any BUSY_IF cycle sets `drop`. At completion with `drop` set, there is no `ifValid`, `ifData` is unchanged, and `drop` clears. `ifFlush` has no effect on a BUSY_MEM transaction.
- Stores complete after the same latency. `memRData` is 0 for a store.
- Simultaneous events: in a cycle where a valid is high, the state is IDLE, so a new request can be accepted at that cycle's edge. Both valids are never high together.

## Timing
- Request sampled at edge E0. `portReq` is high in cycle E0..E1. Data is captured at edge E(LATENCY+1). Valid is high in the cycle after that edge.
- Request-to-valid latency is LATENCY+2 cycles. Back-to-back throughput is one transaction per LATENCY+2 cycles.
- Reset (asynchronous, at any point): state is IDLE; `cnt`, `drop` and every output go to 0. A port response still in flight is ignored. `ifStall`/`memStall` follow their requests combinationally.

## Structure
- `define.v` gains: `ArbStateBus` [1:0], `ArbIdle` 2'b00, `ArbBusyIf` 2'b01, `ArbBusyMem` 2'b10, `ArbLatency` 2, `ByteEnBus` [3:0].
- Single module with no sub-modules. The counter, state register and port registers are all local.

## Test plan
- Reset: assert `resetIn`=0 mid-fetch (BUSY_IF, `cnt`=1) -> all outputs read 0 within the same cycle. After release, no stray `ifValid` appears.
- Single fetch: LATENCY=2, `ifReq`=1, `ifAddr`=0x10, memory returns 0x00500093 -> `portReq` is high for 1 cycle with `portAddr`=0x10, then `ifValid` is high 4 cycles after the request with `ifData`=0x00500093, and `ifStall` drops in that cycle.
- Priority: `ifReq` and `memReq` (load 0x20 -> 0xDEADBEEF) both rise in the same cycle -> the load is served first (`memValid` at +4). The fetch `portReq` follows in the cycle after `memValid`, and `ifStall` stays high throughout.
- Store: `memWrite`=1, `memAddr`=0x0, `memWData`=0x12345678, `memByteEn`=4'b0011 -> the port shows the same values with `portWrite`=1, then `memValid` is high at +4 with `memRData`=0.
- Flush: `ifFlush` pulses in the second BUSY_IF cycle -> no `ifValid` and `ifData` is unchanged. A new fetch at 0x40 is accepted in the following IDLE cycle.
- Latency sweep: LATENCY=1 and LATENCY=7 -> valid arrives at +3 and +9 respectively, and 8 back-to-back fetches complete with no gaps beyond LATENCY+2.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// State encodings line up with the core's ArbIdle/ArbBusyIf/ArbBusyMem values.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle    = 2'b00,
        ArbBusyIf  = 2'b01,
        ArbBusyMem = 2'b10
    } arbState_t;

    localparam int ArbLatency = 2;
    localparam int CntW       = 3;

    typedef logic [3:0] byteEn_t;
    localparam byteEn_t ByteEnAll = 4'b1111;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-ported memory between instruction fetch and
// data access; data requests win, one transaction in flight, fetches can be flushed.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LATENCY = ArbLatency,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              resetIn,
    input  logic              ifReq,
    input  logic [DATA_W-1:0] ifAddr,
    input  logic              ifFlush,
    output logic              ifValid,
    output logic [DATA_W-1:0] ifData,
    output logic              ifStall,
    input  logic              memReq,
    input  logic              memWrite,
    input  logic [DATA_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memWData,
    input  logic [3:0]        memByteEn,
    output logic              memValid,
    output logic [DATA_W-1:0] memRData,
    output logic              memStall,
    output logic              portReq,
    output logic              portWrite,
    output logic [DATA_W-1:0] portAddr,
    output logic [DATA_W-1:0] portWData,
    output logic [3:0]        portByteEn,
    input  logic [DATA_W-1:0] portRData
);

    localparam logic [CntW-1:0] LatCnt = CntW'(LATENCY);

    arbState_t         stateReg, stateNext;
    logic [CntW-1:0]   cntReg, cntNext;
    logic              dropReg, dropNext;
    logic              portReqReg, portReqNext;
    logic              portWriteReg, portWriteNext;
    logic [DATA_W-1:0] portAddrReg, portAddrNext;
    logic [DATA_W-1:0] portWDataReg, portWDataNext;
    byteEn_t           portByteEnReg, portByteEnNext;
    logic              ifValidReg, ifValidNext;
    logic [DATA_W-1:0] ifDataReg, ifDataNext;
    logic              memValidReg, memValidNext;
    logic [DATA_W-1:0] memRDataReg, memRDataNext;

    always_ff @(posedge clk or negedge resetIn) begin
        if (!resetIn) begin
            stateReg      <= ArbIdle;
            cntReg        <= '0;
            dropReg       <= 1'b0;
            portReqReg    <= 1'b0;
            portWriteReg  <= 1'b0;
            portAddrReg   <= '0;
            portWDataReg  <= '0;
            portByteEnReg <= '0;
            ifValidReg    <= 1'b0;
            ifDataReg     <= '0;
            memValidReg   <= 1'b0;
            memRDataReg   <= '0;
        end else begin
            stateReg      <= stateNext;
            cntReg        <= cntNext;
            dropReg       <= dropNext;
            portReqReg    <= portReqNext;
            portWriteReg  <= portWriteNext;
            portAddrReg   <= portAddrNext;
            portWDataReg  <= portWDataNext;
            portByteEnReg <= portByteEnNext;
            ifValidReg    <= ifValidNext;
            ifDataReg     <= ifDataNext;
            memValidReg   <= memValidNext;
            memRDataReg   <= memRDataNext;
        end
    end

    always_comb begin
        stateNext      = stateReg;
        cntNext        = cntReg;
        dropNext       = dropReg;
        portReqNext    = 1'b0;
        portWriteNext  = portWriteReg;
        portAddrNext   = portAddrReg;
        portWDataNext  = portWDataReg;
        portByteEnNext = portByteEnReg;
        ifValidNext    = 1'b0;
        ifDataNext     = ifDataReg;
        memValidNext   = 1'b0;
        memRDataNext   = memRDataReg;

        case (stateReg)
            ArbIdle: begin
                if (memReq) begin
                    stateNext      = ArbBusyMem;
                    cntNext        = LatCnt;
                    dropNext       = 1'b0;
                    portReqNext    = 1'b1;
                    portWriteNext  = memWrite;
                    portAddrNext   = memAddr;
                    portWDataNext  = memWData;
                    portByteEnNext = memWrite ? memByteEn : ByteEnAll;
                end else if (ifReq && !ifFlush) begin
                    stateNext      = ArbBusyIf;
                    cntNext        = LatCnt;
                    dropNext       = 1'b0;
                    portReqNext    = 1'b1;
                    portWriteNext  = 1'b0;
                    portAddrNext   = ifAddr;
                    portWDataNext  = '0;
                    portByteEnNext = ByteEnAll;
                end
            end
            ArbBusyIf: begin
                // A flush landing in the completion cycle itself still discards the fetch.
                if (cntReg == '0) begin
                    stateNext = ArbIdle;
                    dropNext  = 1'b0;
                    if (!(dropReg || ifFlush)) begin
                        ifValidNext = 1'b1;
                        ifDataNext  = portRData;
                    end
                end else begin
                    cntNext  = cntReg - 1'b1;
                    dropNext = dropReg | ifFlush;
                end
            end
            ArbBusyMem: begin
                if (cntReg == '0) begin
                    stateNext    = ArbIdle;
                    memValidNext = 1'b1;
                    memRDataNext = portWriteReg ? '0 : portRData;
                end else begin
                    cntNext = cntReg - 1'b1;
                end
            end
            default: begin
                stateNext = ArbIdle;
            end
        endcase
    end

    assign ifValid    = ifValidReg;
    assign ifData     = ifDataReg;
    assign ifStall    = ifReq & ~ifValidReg;
    assign memValid   = memValidReg;
    assign memRData   = memRDataReg;
    assign memStall   = memReq & ~memValidReg;
    assign portReq    = portReqReg;
    assign portWrite  = portWriteReg;
    assign portAddr   = portAddrReg;
    assign portWData  = portWDataReg;
    assign portByteEn = portByteEnReg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance 0 runs at LATENCY=2 for the
// functional cases, instances 1 and 2 run LATENCY=1 and 7 back-to-back fetch sweeps.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    function automatic int latOf(input int i);
        case (i)
            1:       return 1;
            2:       return 7;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] memData(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h00500093;
            32'h20:  return 32'hDEADBEEF;
            default: return (a * 32'h01010101) ^ 32'h13579BDF;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetIn;
    logic        ifReq     [NI];
    logic [31:0] ifAddr    [NI];
    logic        ifFlush   [NI];
    logic        ifValid   [NI];
    logic [31:0] ifData    [NI];
    logic        ifStall   [NI];
    logic        memReq    [NI];
    logic        memWrite  [NI];
    logic [31:0] memAddr   [NI];
    logic [31:0] memWData  [NI];
    logic [3:0]  memByteEn [NI];
    logic        memValid  [NI];
    logic [31:0] memRData  [NI];
    logic        memStall  [NI];
    logic        portReq   [NI];
    logic        portWrite [NI];
    logic [31:0] portAddr  [NI];
    logic [31:0] portWData [NI];
    logic [3:0]  portByteEn[NI];
    logic [31:0] portRData [NI];

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic [31:0] pipe [8];

        mem_port_arbiter #(.LATENCY(latOf(gi)), .DATA_W(32)) dut (
            .clk       (clk),
            .resetIn   (resetIn),
            .ifReq     (ifReq[gi]),
            .ifAddr    (ifAddr[gi]),
            .ifFlush   (ifFlush[gi]),
            .ifValid   (ifValid[gi]),
            .ifData    (ifData[gi]),
            .ifStall   (ifStall[gi]),
            .memReq    (memReq[gi]),
            .memWrite  (memWrite[gi]),
            .memAddr   (memAddr[gi]),
            .memWData  (memWData[gi]),
            .memByteEn (memByteEn[gi]),
            .memValid  (memValid[gi]),
            .memRData  (memRData[gi]),
            .memStall  (memStall[gi]),
            .portReq   (portReq[gi]),
            .portWrite (portWrite[gi]),
            .portAddr  (portAddr[gi]),
            .portWData (portWData[gi]),
            .portByteEn(portByteEn[gi]),
            .portRData (portRData[gi])
        );

        // Memory model: data is only meaningful exactly LATENCY cycles after the strobe.
        always @(posedge clk) begin
            pipe[0] <= portReq[gi] ? memData(portAddr[gi]) : 32'hBAD0BAD0;
            for (int k = 1; k < 8; k++) pipe[k] <= pipe[k-1];
        end
        assign portRData[gi] = pipe[latOf(gi)-1];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitValid(input int i, input bit isMem, output int cyc);
        cyc = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if ((isMem ? memValid[i] : ifValid[i]) === 1'b1) begin
                cyc = n;
                break;
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " portReq"},    32'(portReq[0]),    32'h0);
        check({tag, " portAddr"},   portAddr[0],        32'h0);
        check({tag, " portByteEn"}, 32'(portByteEn[0]), 32'h0);
        check({tag, " ifValid"},    32'(ifValid[0]),    32'h0);
        check({tag, " ifData"},     ifData[0],          32'h0);
        check({tag, " memValid"},   32'(memValid[0]),   32'h0);
        check({tag, " memRData"},   memRData[0],        32'h0);
    endtask

    initial begin
        int cyc;
        int strays;
        logic [31:0] addr;

        for (int i = 0; i < NI; i++) begin
            ifReq[i]     = 1'b0;
            ifAddr[i]    = '0;
            ifFlush[i]   = 1'b0;
            memReq[i]    = 1'b0;
            memWrite[i]  = 1'b0;
            memAddr[i]   = '0;
            memWData[i]  = '0;
            memByteEn[i] = '0;
        end
        resetIn = 1'b0;
        step(2);
        checkAllZero("reset");
        resetIn = 1'b1;
        step(1);

        // Single fetch
        ifReq[0] = 1'b1; ifAddr[0] = 32'h10;
        step(1);
        check("fetch portReq",    32'(portReq[0]),    32'h1);
        check("fetch portAddr",   portAddr[0],        32'h10);
        check("fetch portByteEn", 32'(portByteEn[0]), 32'hF);
        check("fetch portWrite",  32'(portWrite[0]),  32'h0);
        check("fetch ifStall",    32'(ifStall[0]),    32'h1);
        step(1);
        check("fetch portReq off", 32'(portReq[0]),   32'h0);
        check("fetch portAddr hold", portAddr[0],     32'h10);
        step(1);
        check("fetch early valid", 32'(ifValid[0]),   32'h0);
        step(1);
        check("fetch ifValid",    32'(ifValid[0]),    32'h1);
        check("fetch ifData",     ifData[0],          32'h00500093);
        check("fetch ifStall low", 32'(ifStall[0]),   32'h0);
        ifReq[0] = 1'b0;
        step(1);
        check("fetch valid pulse", 32'(ifValid[0]),   32'h0);
        $display("txn fetch addr=00000010 data=%h", ifData[0]);

        // Priority: load and fetch together
        ifReq[0] = 1'b1; ifAddr[0] = 32'h30;
        memReq[0] = 1'b1; memWrite[0] = 1'b0; memAddr[0] = 32'h20;
        step(1);
        check("prio portAddr",    portAddr[0],        32'h20);
        step(3);
        check("prio memValid",    32'(memValid[0]),   32'h1);
        check("prio memRData",    memRData[0],        32'hDEADBEEF);
        check("prio ifStall",     32'(ifStall[0]),    32'h1);
        check("prio ifValid",     32'(ifValid[0]),    32'h0);
        memReq[0] = 1'b0;
        step(1);
        check("prio fetch portReq",  32'(portReq[0]), 32'h1);
        check("prio fetch portAddr", portAddr[0],     32'h30);
        check("prio memValid pulse", 32'(memValid[0]), 32'h0);
        step(3);
        check("prio ifValid late", 32'(ifValid[0]),   32'h1);
        check("prio ifData",      ifData[0],          memData(32'h30));
        ifReq[0] = 1'b0;
        $display("txn load addr=00000020 then fetch addr=00000030 data=%h", ifData[0]);

        // Store
        memReq[0] = 1'b1; memWrite[0] = 1'b1; memAddr[0] = 32'h0;
        memWData[0] = 32'h12345678; memByteEn[0] = 4'b0011;
        step(1);
        check("store portReq",    32'(portReq[0]),    32'h1);
        check("store portWrite",  32'(portWrite[0]),  32'h1);
        check("store portAddr",   portAddr[0],        32'h0);
        check("store portWData",  portWData[0],       32'h12345678);
        check("store portByteEn", 32'(portByteEn[0]), 32'h3);
        step(3);
        check("store memValid",   32'(memValid[0]),   32'h1);
        check("store memRData",   memRData[0],        32'h0);
        memReq[0] = 1'b0; memWrite[0] = 1'b0;
        $display("txn store addr=00000000 wdata=12345678 be=0011");

        // Flush in the second busy cycle, then a new fetch
        ifReq[0] = 1'b1; ifAddr[0] = 32'h50;
        step(2);
        ifReq[0] = 1'b0; ifFlush[0] = 1'b1;
        step(1);
        ifFlush[0] = 1'b0; ifReq[0] = 1'b1; ifAddr[0] = 32'h40;
        step(1);
        check("flush ifValid",    32'(ifValid[0]),    32'h0);
        check("flush ifData kept", ifData[0],         memData(32'h30));
        check("flush idle portReq", 32'(portReq[0]),  32'h0);
        step(1);
        check("flush new portReq",  32'(portReq[0]),  32'h1);
        check("flush new portAddr", portAddr[0],      32'h40);
        step(3);
        check("flush new ifValid", 32'(ifValid[0]),   32'h1);
        check("flush new ifData",  ifData[0],         memData(32'h40));
        ifReq[0] = 1'b0;
        $display("txn flushed fetch addr=00000050, fetch addr=00000040 data=%h", ifData[0]);

        // Asynchronous reset with the fetch at cnt==1
        ifReq[0] = 1'b1; ifAddr[0] = 32'h60;
        step(2);
        resetIn = 1'b0;
        #1;
        checkAllZero("midreset");
        ifReq[0] = 1'b0;
        step(1);
        resetIn = 1'b1;
        strays = 0;
        for (int n = 0; n < 8; n++) begin
            step(1);
            if (ifValid[0] === 1'b1) strays++;
        end
        check("midreset stray ifValid", 32'(strays), 32'h0);
        $display("txn reset during fetch addr=00000060");

        // Latency sweeps: 8 back-to-back fetches each
        for (int i = 1; i < NI; i++) begin
            addr = 32'h100;
            ifReq[i] = 1'b1; ifAddr[i] = addr;
            for (int k = 0; k < 8; k++) begin
                waitValid(i, 1'b0, cyc);
                check($sformatf("L%0d fetch%0d gap", latOf(i), k), 32'(cyc), 32'(latOf(i) + 2));
                check($sformatf("L%0d fetch%0d data", latOf(i), k), ifData[i], memData(addr));
                $display("txn L%0d fetch addr=%h data=%h cycles=%0d", latOf(i), addr, ifData[i], cyc);
                addr = addr + 32'h4;
                if (k == 7) ifReq[i] = 1'b0;
                else        ifAddr[i] = addr;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
